// File: rtl/cmult_acc_dump.sv
// Integrate-and-dump correlator behind the complex multiplier.
// It sums a programmable number of (re, im) products, then rounds, shifts
// and saturates each sum to 16 bits. The result is one packed IQ word per block.
// Optional feature macro: CMULT_ACC_TLAST_EN adds s_last / m_last, so a block
// can end early on an accepted s_last beat.
module cmult_acc_dump #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ACC_WIDTH   = 48,
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned SHIFT_WIDTH = 6
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic signed [DATA_WIDTH-1:0]  s_cr,
    input  logic signed [DATA_WIDTH-1:0]  s_ci,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic        [LEN_WIDTH-1:0]   cfg_len,
    input  logic        [SHIFT_WIDTH-1:0] cfg_shift,
    output logic        [31:0]            m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          sat_flag,
`ifdef CMULT_ACC_TLAST_EN
    input  logic                          s_last,
    output logic                          m_last,
`endif
    input  logic                          sat_clr
);

    localparam int unsigned EXT_W = ACC_WIDTH - DATA_WIDTH;
    localparam int unsigned RND_W = ACC_WIDTH + 1;   // headroom for the rounding add
    localparam int unsigned OUT_W = 16;

    localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'(32'sd32767);
    localparam logic signed [RND_W-1:0] SAT_MIN = RND_W'(-32'sd32768);

    typedef enum logic [0:0] {
        ST_FIRST = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    typedef struct packed {
        logic [OUT_W-1:0] i;
        logic [OUT_W-1:0] q;
    } iq_t;

    state_t                         state_q,  state_d;
    logic signed [ACC_WIDTH-1:0]    acc_re_q, acc_re_d;
    logic signed [ACC_WIDTH-1:0]    acc_im_q, acc_im_d;
    logic        [LEN_WIDTH-1:0]    cnt_q,    cnt_d;
    logic        [LEN_WIDTH-1:0]    len_q,    len_d;
    logic        [SHIFT_WIDTH-1:0]  shift_q,  shift_d;
    iq_t                            m_data_q, m_data_d;
    logic                           m_valid_q, m_valid_d;
    logic                           sat_q,    sat_d;
    logic                           m_last_q, m_last_d;

    logic                           accept_c;
    logic                           last_c;
    logic                           final_c;
    logic signed [ACC_WIDTH-1:0]    in_re_c, in_im_c;
    logic signed [ACC_WIDTH-1:0]    sum_re_c, sum_im_c;
    logic        [SHIFT_WIDTH-1:0]  shift_sel_c;
    logic        [OUT_W:0]          res_re_c, res_im_c;

    // Round half-up, arithmetic shift, saturate; returns {clipped, value}.
    function automatic logic [OUT_W:0] round_sat(input logic signed [ACC_WIDTH-1:0] sum,
                                                 input logic [SHIFT_WIDTH-1:0] sh);
        logic signed [RND_W-1:0] ext;
        logic signed [RND_W-1:0] rnd;
        logic signed [RND_W-1:0] shr;
        ext = {sum[ACC_WIDTH-1], sum};
        rnd = '0;
        if (sh != '0) begin
            rnd = RND_W'(1) << (sh - SHIFT_WIDTH'(1));
        end
        shr = (ext + rnd) >>> sh;
        if (shr > SAT_MAX) begin
            round_sat = {1'b1, 16'h7fff};
        end else if (shr < SAT_MIN) begin
            round_sat = {1'b1, 16'h8000};
        end else begin
            round_sat = {1'b0, shr[OUT_W-1:0]};
        end
    endfunction

`ifdef CMULT_ACC_TLAST_EN
    assign last_c = s_last;
    assign m_last = m_last_q;
`else
    assign last_c = 1'b0;
`endif

    // Input stalls only while an undelivered result is held; closed in reset.
    assign s_ready  = aresetn && !(m_valid_q && !m_ready);
    assign accept_c = s_valid && s_ready;

    assign in_re_c = {{EXT_W{s_cr[DATA_WIDTH-1]}}, s_cr};
    assign in_im_c = {{EXT_W{s_ci[DATA_WIDTH-1]}}, s_ci};

    // Next-state, accumulate and dump logic.
    always_comb begin
        state_d   = state_q;
        acc_re_d  = acc_re_q;
        acc_im_d  = acc_im_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        shift_d   = shift_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        sat_d     = sat_q;
        m_last_d  = m_last_q;

        // The first beat starts from zero and uses the live config; later beats use the latched block config.
        if (state_q == ST_FIRST) begin
            sum_re_c    = in_re_c;
            sum_im_c    = in_im_c;
            shift_sel_c = cfg_shift;
            final_c     = (cfg_len == LEN_WIDTH'(1)) || last_c;
        end else begin
            sum_re_c    = acc_re_q + in_re_c;
            sum_im_c    = acc_im_q + in_im_c;
            shift_sel_c = shift_q;
            final_c     = (cnt_q == (len_q - LEN_WIDTH'(1))) || last_c;
        end

        res_re_c = round_sat(sum_re_c, shift_sel_c);
        res_im_c = round_sat(sum_im_c, shift_sel_c);

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        if (sat_clr) begin
            sat_d = 1'b0;
        end

        if (accept_c) begin
            acc_re_d = sum_re_c;
            acc_im_d = sum_im_c;
            if (state_q == ST_FIRST) begin
                len_d   = cfg_len;
                shift_d = cfg_shift;
                cnt_d   = LEN_WIDTH'(1);
            end else begin
                cnt_d   = cnt_q + LEN_WIDTH'(1);
            end
            if (final_c) begin
                m_data_d.i = res_re_c[OUT_W-1:0];
                m_data_d.q = res_im_c[OUT_W-1:0];
                m_valid_d  = 1'b1;
                m_last_d   = last_c;
                if (res_re_c[OUT_W] || res_im_c[OUT_W]) begin
                    sat_d = 1'b1;
                end
                state_d = ST_FIRST;
            end else begin
                state_d = ST_ACCUM;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_FIRST;
            acc_re_q  <= '0;
            acc_im_q  <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            shift_q   <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            sat_q     <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_re_q  <= acc_re_d;
            acc_im_q  <= acc_im_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            shift_q   <= shift_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            sat_q     <= sat_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_cmult_acc_dump.sv
`timescale 1ns/1ps
module tb_cmult_acc_dump;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_cr, s_ci;
    logic        s_valid, s_ready;
    logic [15:0] cfg_len;
    logic [5:0]  cfg_shift;
    logic [31:0] m_data;
    logic        m_valid, m_ready;
    logic        sat_flag, sat_clr;
    logic        tb_last;
    logic        m_last_w;

    int checks = 0;
    int errors = 0;

    cmult_acc_dump dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_cr     (s_cr),
        .s_ci     (s_ci),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .cfg_len  (cfg_len),
        .cfg_shift(cfg_shift),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .sat_flag (sat_flag),
`ifdef CMULT_ACC_TLAST_EN
        .s_last   (tb_last),
        .m_last   (m_last_w),
`endif
        .sat_clr  (sat_clr)
    );

`ifndef CMULT_ACC_TLAST_EN
    assign m_last_w = 1'b0;
`endif

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [32:0] exp_q[$];        // {last, I, Q} of results not yet delivered
    bit          in_blk = 0;
    int          blk_len, blk_shift, blk_cnt;
    longint      sum_i, sum_q;
    bit          sat_m = 0;
    logic [31:0] last_out = '0;
    int          outs = 0;

    function automatic logic [15:0] rs(input longint s, input int sh, output bit clip);
        longint r;
        r = s;
        if (sh > 0) r = r + (longint'(1) << (sh - 1));
        r = r >>> sh;
        clip = 1'b0;
        if (r > 32767)  begin r = 32767;  clip = 1'b1; end
        if (r < -32768) begin r = -32768; clip = 1'b1; end
        return r[15:0];
    endfunction

    task automatic model_beat(input logic [31:0] cr, input logic [31:0] ci, input bit lst,
                              inout bit nsat);
        bit ci_clip, cq_clip;
        logic [15:0] vi, vq;
        if (!in_blk) begin
            in_blk    = 1;
            blk_len   = (cfg_len == 0) ? 65536 : int'(cfg_len);
            blk_shift = int'(cfg_shift);
            blk_cnt   = 0;
            sum_i     = 0;
            sum_q     = 0;
        end
        sum_i = sum_i + longint'($signed(cr));
        sum_q = sum_q + longint'($signed(ci));
        blk_cnt++;
        if (blk_cnt == blk_len || lst) begin
            vi = rs(sum_i, blk_shift, ci_clip);
            vq = rs(sum_q, blk_shift, cq_clip);
            exp_q.push_back({lst, vi, vq});
            if (ci_clip || cq_clip) nsat = 1;
            in_blk = 0;
        end
    endtask

    // Sample everything on the falling edge: inputs and outputs are both settled here.
    always @(negedge aclk) begin
        bit nsat;
        bit have;
        if (!aresetn) begin
            exp_q.delete();
            in_blk = 0;
            sat_m  = 0;
        end
        have = (exp_q.size() > 0);
        chk("s_ready", {31'd0, s_ready}, {31'd0, aresetn && !(have && !m_ready)});
        chk("m_valid", {31'd0, m_valid}, {31'd0, have});
        if (have) begin
            chk("m_data", m_data, exp_q[0][31:0]);
`ifdef CMULT_ACC_TLAST_EN
            chk("m_last", {31'd0, m_last_w}, {31'd0, exp_q[0][32]});
`endif
        end
        chk("sat_flag", {31'd0, sat_flag}, {31'd0, sat_m});
        if (aresetn) begin
            nsat = sat_m;
            if (sat_clr) nsat = 0;
            if (have && m_ready) begin
                last_out = m_data;
                outs++;
                void'(exp_q.pop_front());
            end
            if (s_valid && !(have && !m_ready)) model_beat(s_cr, s_ci, tb_last, nsat);
            sat_m = nsat;
        end
    end

    // ---------------- stimulus ----------------
    bit rnd_ready = 0;

    initial begin
        forever begin
            @(posedge aclk); #1;
            if (rnd_ready) m_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic tick();
        @(posedge aclk); #1;
    endtask

    task automatic send(input logic [31:0] cr, input logic [31:0] ci, input bit lst);
        bit ok;
        ok      = 0;
        s_cr    = cr;
        s_ci    = ci;
        tb_last = lst;
        s_valid = 1'b1;
        for (int n = 0; n < 2000 && !ok; n++) begin
            @(negedge aclk);
            if (s_ready) ok = 1;
            tick();
        end
        s_valid = 1'b0;
        tb_last = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_outs(input int target);
        int n;
        n = 0;
        while (outs < target && n < 2000) begin
            tick();
            n++;
        end
        if (outs < target) chk("out_timeout", outs, target);
    endtask

    initial begin
        int base;
        aresetn = 1'b0; s_cr = '0; s_ci = '0; s_valid = 1'b0; tb_last = 1'b0;
        cfg_len = 16'd1; cfg_shift = '0; m_ready = 1'b1; sat_clr = 1'b0;
        repeat (3) tick();
        chk("rst_m_data", m_data, 32'h0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        aresetn = 1'b1;
        tick();

        // Basic sum of four beats, result one cycle after the last accept
        cfg_len = 16'd4; cfg_shift = 6'd0;
        for (int k = 0; k < 4; k++) send(32'd100, -32'sd50, 1'b0);
        chk("basic_valid", {31'd0, m_valid}, 32'd1);
        chk("basic_data", m_data, 32'h0190ff38);
        chk("basic_sat", {31'd0, sat_flag}, 32'd0);
        tick();

        // Round half-up on single-beat blocks
        cfg_len = 16'd1; cfg_shift = 6'd2;
        send(32'd6, -32'sd6, 1'b0);
        chk("round_a", m_data, 32'h0002ffff);
        send(32'd5, -32'sd5, 1'b0);
        chk("round_b", m_data, 32'h0001ffff);
        tick();

        // Saturation and sticky flag clear
        cfg_len = 16'd2; cfg_shift = 6'd0;
        send(32'h00007000, 32'hffff8000, 1'b0);
        send(32'h00007000, 32'hffff8000, 1'b0);
        chk("sat_data", m_data, 32'h7fff8000);
        chk("sat_set", {31'd0, sat_flag}, 32'd1);
        sat_clr = 1'b1; tick(); sat_clr = 1'b0;
        chk("sat_clr", {31'd0, sat_flag}, 32'd0);

        // Backpressure: first result held, input stalled, then drained in order
        cfg_len = 16'd1; cfg_shift = 6'd0; m_ready = 1'b0;
        base = outs;
        send(32'd1, 32'd1, 1'b0);
        s_cr = 32'd2; s_ci = 32'd2; s_valid = 1'b1;
        repeat (3) tick();
        chk("bp_stall", {31'd0, s_ready}, 32'd0);
        chk("bp_hold", m_data, 32'h00010001);
        m_ready = 1'b1;
        send(32'd2, 32'd2, 1'b0);
        send(32'd3, 32'd3, 1'b0);
        wait_outs(base + 3);
        tick();
        chk("bp_count", outs, base + 3);
        chk("bp_last", last_out, 32'h00030003);

        // Config change mid-block is ignored
        cfg_len = 16'd8; base = outs;
        for (int k = 0; k < 3; k++) send(32'd1, 32'd2, 1'b0);
        cfg_len = 16'd2;
        for (int k = 0; k < 2; k++) send(32'd1, 32'd2, 1'b0);
        tick();
        chk("cfg_no_early", outs, base);
        for (int k = 0; k < 3; k++) send(32'd1, 32'd2, 1'b0);
        tick();
        chk("cfg_count", outs, base + 1);
        chk("cfg_data", last_out, 32'h00080010);

        // Reset mid-block discards the partial sum
        cfg_len = 16'd8;
        for (int k = 0; k < 5; k++) send(32'd100, 32'd100, 1'b0);
        aresetn = 1'b0; tick();
        chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        aresetn = 1'b1; cfg_len = 16'd2; tick();
        send(32'd3, 32'd4, 1'b0);
        send(32'd3, 32'd4, 1'b0);
        tick();
        chk("post_rst_data", last_out, 32'h00060008);

        // cfg_len 0 means 65536 beats
        cfg_len = 16'd0; cfg_shift = 6'd16; base = outs;
        for (int k = 0; k < 65535; k++) send(32'd1, 32'hffffffff, 1'b0);
        tick();
        chk("len0_no_early", outs, base);
        send(32'd1, 32'hffffffff, 1'b0);
        tick();
        chk("len0_count", outs, base + 1);
        chk("len0_data", last_out, 32'h0001ffff);

`ifdef CMULT_ACC_TLAST_EN
        // Early termination via s_last, then a full-length block
        cfg_len = 16'd8; cfg_shift = 6'd0; base = outs;
        send(32'd1, 32'd0, 1'b0);
        send(32'd1, 32'd0, 1'b0);
        send(32'd1, 32'd0, 1'b1);
        chk("tlast_data", m_data, 32'h00030000);
        chk("tlast_flag", {31'd0, m_last_w}, 32'd1);
        for (int k = 0; k < 8; k++) send(32'd1, 32'd0, 1'b0);
        chk("full_data", m_data, 32'h00080000);
        chk("full_flag", {31'd0, m_last_w}, 32'd0);
        tick();
`endif

        // Randomized traffic with backpressure, gaps, config churn and a reset
        rnd_ready = 1;
        for (int b = 0; b < 800; b++) begin
            logic [31:0] vr, vi;
            if ($urandom_range(0, 3) == 0) begin
                cfg_len   = 16'($urandom_range(1, 5));
                cfg_shift = 6'($urandom_range(0, 32));
            end
            sat_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 0) begin
                vr = $urandom; vi = $urandom;
            end else begin
                vr = 32'($signed(16'($urandom))); vi = 32'($signed(16'($urandom)));
            end
`ifdef CMULT_ACC_TLAST_EN
            send(vr, vi, ($urandom_range(0, 7) == 0));
`else
            send(vr, vi, 1'b0);
`endif
            repeat ($urandom_range(0, 2)) tick();
            if (b == 400) begin
                aresetn = 1'b0; tick(); aresetn = 1'b1;
            end
        end
        sat_clr = 1'b0;
        rnd_ready = 0;
        m_ready = 1'b1;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
